exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt sequencer that sits directly upstream of the CP0 register file and owns its single write port during trap entry and ERET.
- Accepts synchronous exception reports from the pipeline commit stage, asynchronous hardware interrupts and ERET requests.
- Serialises the resulting EPC/Cause/Status writes into CP0 one per cycle, then emits a PC redirect plus a pipeline flush.
- Stalls the pipeline while a sequence is in flight.

Parameters:
- EXC_VECTOR, 32'h0000_0180, handler entry address driven on redirect_pc for exceptions and interrupts.
- INT_CODE, 5'd0, ExcCode written into Cause for interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exc_valid  in  1  commit stage reports a synchronous exception this cycle
- exc_code  in  5  ExcCode of the reported exception
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- eret  in  1  ERET at commit
- hw_int  in  6  level-sensitive hardware interrupt lines
- cp0_status  in  32  current Status (CP0 reg 12) value
- cp0_epc  in  32  current EPC from CP0 (write-forwarded)
- cp0_addrW  out  5  CP0 write address
- cp0_selW  out  6  CP0 write select; always 0
- cp0_din  out  32  CP0 write data
- cp0_write  out  1  CP0 write enable
- stall  out  1  freeze pipeline
- flush  out  1  one-cycle pipeline flush
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- Reset: state IDLE. cp0_write, stall, flush and redirect_valid are 0. cp0_addrW, cp0_din, redirect_pc and the latched request registers are 0. rst mid-sequence aborts immediately; no further CP0 writes.
- Interrupt pending: int_req = Status.IE(0) & ~Status.EXL(1) & |(hw_int & Status.IM[15:10]).
- Priority, sampled only in IDLE: exc_valid > int_req > eret. Lower-priority requests in the same cycle are dropped. The pipeline re-presents them after the flush if they are still valid.
- Accept cycle (IDLE, request present):
  - Latch the data:
    - EPC value = exc_bd ? exc_pc-4 : exc_pc.
    - Interrupts use exc_pc as the restart PC; the commit stage supplies the next-to-commit PC.
    - Cause = {exc_bd, 15'b0, hw_int, 2'b00, 1'b0, code, 2'b00}, where code = exc_code or INT_CODE.
  - Set stall=1 and move to the first write state.
- Exception/interrupt path:
  - WR_EPC: addr 14, din = latched EPC.
  - WR_CAUSE: addr 13.
  - WR_STATUS: addr 12, din = cp0_status | 32'h2 (EXL set).
  - REDIRECT: cp0_write=0; flush=1, redirect_valid=1, redirect_pc=EXC_VECTOR; stall=0; then IDLE.
  - One write per cycle with cp0_write=1 and stall=1 throughout.
  - Total latency: accept + 4 cycles.
- ERET path:
  - WR_STATUS_E: addr 12, din = cp0_status & ~32'h2.
  - REDIRECT_E: redirect_pc = cp0_epc as sampled in that cycle; flush=1, redirect_valid=1; then IDLE.
  - ERET with EXL already 0 still executes; EPC contents are taken as-is.
- Requests arriving while not IDLE are ignored. stall keeps the pipeline holding them.
- EPC arithmetic is 32-bit wrap: exc_pc=0 with bd gives 32'hFFFF_FFFC.
- Outputs are registered from state; no combinational path from inputs to cp0_write.

Optional Feature:
- Macro: EXC_CTRL_TIMER_EN.
- With the macro defined:
  - Adds ports mtc0_valid (1), mtc0_addr (5), mtc0_data (32) for pipeline MTC0 snooping.
  - Internal 32-bit count increments every cycle and reloads on an MTC0 to reg 9.
  - Internal compare loads on an MTC0 to reg 11, which also clears timer_ip.
  - Equal count and compare sets timer_ip, which ORs into hw_int[5].
- Without the macro: no extra ports; hw_int passes through unchanged.

Decomposition:
- Shared package cp0_pkg:
  - CP0 register indices: STATUS=12, CAUSE=13, EPC=14, COUNT=9, COMPARE=11.
  - Status bit positions: IE=0, EXL=1, IM=15:8.
  - Cause field positions.
  - ExcCode constants: INT, ADEL, ADES, SYS, BP, RI, OV.
  - State enum.
- One sub-module exc_timer, instantiated only under EXC_CTRL_TIMER_EN.

Test Plan:
- exc_valid with code 5'd12, exc_pc 32'h0040_0010, bd=0:
  - Writes EPC=32'h0040_0010, then Cause=32'h0000_0030, then Status|2 on consecutive cycles.
  - Next cycle: redirect_pc=32'h180 with flush=1.
- Same exception with bd=1 -> EPC=32'h0040_000C and Cause bit31=1.
- hw_int=6'b000001 with Status=32'h0000_0401 -> interrupt sequence with Cause[10]=1, ExcCode 0.
- Same interrupt with Status=32'h0000_0403 (EXL set) -> no action.
- eret with cp0_epc=32'h0040_0020 and Status=32'h3 -> Status write 32'h1, then redirect_pc=32'h0040_0020.
- exc_valid and eret in the same cycle -> exception path only.
- rst asserted during WR_CAUSE -> cp0_write=0 on the next cycle, no redirect, stall=0.
- Timer (macro on): MTC0 reg 11 = 5, MTC0 reg 9 = 0 -> timer_ip rises 5 cycles later; the interrupt is taken when IM7 and IE are set.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register indices, Status/Cause field positions,
// ExcCode values and the exception sequencer state encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // Status bit positions
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;  // hardware interrupt pending, 6 bits
  localparam int CAUSE_EXC_LO = 2;   // ExcCode, 5 bits

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_STATUS,
    S_REDIRECT,
    S_WR_STATUS_E,
    S_REDIRECT_E
  } exc_state_t;

  // Assemble the Cause value written on trap entry.
  function automatic logic [31:0] make_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    return {bd, 15'b0, ip, 2'b00, 1'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/exc_timer.sv
// Count/Compare timer snooping pipeline MTC0 writes; raises a sticky
// timer_ip when Count matches Compare, cleared by a write to Compare.
module exc_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        timer_ip
);

  logic [31:0] count;
  logic [31:0] compare;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = mtc0_valid && (mtc0_addr == CP0_COUNT);
  assign wr_compare = mtc0_valid && (mtc0_addr == CP0_COMPARE);

  // Free-running count, compare register and sticky match flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      compare  <= '0;
      timer_ip <= 1'b0;
    end else begin
      count <= wr_count ? mtc0_data : count + 32'd1;
      if (wr_compare) compare <= mtc0_data;
      if (wr_compare)              timer_ip <= 1'b0;
      else if (count == compare)   timer_ip <= 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer owning the CP0 write port during trap entry
// and ERET. Define EXC_CTRL_TIMER_EN to add the Count/Compare timer, whose
// interrupt ORs into hw_int[5].
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [4:0]  INT_CODE   = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
`ifdef EXC_CTRL_TIMER_EN
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
`endif
  output logic [4:0]  cp0_addrW,
  output logic [5:0]  cp0_selW,
  output logic [31:0] cp0_din,
  output logic        cp0_write,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  exc_state_t  state;
  logic [31:0] cause_q;
  logic [5:0]  hw_eff;
  logic        int_req;

`ifdef EXC_CTRL_TIMER_EN
  logic timer_ip;

  exc_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .mtc0_valid (mtc0_valid),
    .mtc0_addr  (mtc0_addr),
    .mtc0_data  (mtc0_data),
    .timer_ip   (timer_ip)
  );

  assign hw_eff = hw_int | {timer_ip, 5'b0};
`else
  assign hw_eff = hw_int;
`endif

  assign cp0_selW = 6'd0;
  assign int_req  = cp0_status[ST_IE] & ~cp0_status[ST_EXL]
                  & (|(hw_eff & cp0_status[ST_IM_HI:ST_IM_HI-5]));

  // Sequencer: one CP0 write per cycle, then redirect+flush; outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cause_q        <= '0;
      cp0_addrW      <= '0;
      cp0_din        <= '0;
      cp0_write      <= 1'b0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          cp0_write      <= 1'b0;
          stall          <= 1'b0;
          if (exc_valid || int_req) begin
            // Exception wins over interrupt; lower-priority requests drop
            cause_q   <= make_cause(exc_bd, hw_eff, exc_valid ? exc_code : INT_CODE);
            cp0_addrW <= CP0_EPC;
            cp0_din   <= exc_bd ? exc_pc - 32'd4 : exc_pc;
            cp0_write <= 1'b1;
            stall     <= 1'b1;
            state     <= S_WR_EPC;
          end else if (eret) begin
            cp0_addrW <= CP0_STATUS;
            cp0_din   <= cp0_status & ~32'h2;
            cp0_write <= 1'b1;
            stall     <= 1'b1;
            state     <= S_WR_STATUS_E;
          end
        end
        S_WR_EPC: begin
          cp0_addrW <= CP0_CAUSE;
          cp0_din   <= cause_q;
          state     <= S_WR_CAUSE;
        end
        S_WR_CAUSE: begin
          cp0_addrW <= CP0_STATUS;
          cp0_din   <= cp0_status | 32'h2;
          state     <= S_WR_STATUS;
        end
        S_WR_STATUS: begin
          cp0_write      <= 1'b0;
          stall          <= 1'b0;
          flush          <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= EXC_VECTOR;
          state          <= S_REDIRECT;
        end
        S_WR_STATUS_E: begin
          cp0_write      <= 1'b0;
          stall          <= 1'b0;
          flush          <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= cp0_epc;
          state          <= S_REDIRECT_E;
        end
        S_REDIRECT, S_REDIRECT_E: begin
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized
// transactions compared cycle by cycle against a transaction-level model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        mtc0_valid;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  cp0_addrW;
  logic [5:0]  cp0_selW;
  logic [31:0] cp0_din;
  logic        cp0_write;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [31:0] obs_din[$];
  logic [4:0]  obs_addr[$];
  logic [31:0] obs_rpc;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_bd         (exc_bd),
    .eret           (eret),
    .hw_int         (hw_int),
    .cp0_status     (cp0_status),
    .cp0_epc        (cp0_epc),
`ifdef EXC_CTRL_TIMER_EN
    .mtc0_valid     (mtc0_valid),
    .mtc0_addr      (mtc0_addr),
    .mtc0_data      (mtc0_data),
`endif
    .cp0_addrW      (cp0_addrW),
    .cp0_selW       (cp0_selW),
    .cp0_din        (cp0_din),
    .cp0_write      (cp0_write),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Expected per-cycle outputs after the accept edge, from the trap rules.
  function automatic void model(input logic ev, input logic [4:0] code, input logic [31:0] pc,
                                input logic bd, input logic er, input logic [5:0] hw,
                                input logic [31:0] st, input logic [31:0] epc);
    logic        ir;
    logic [31:0] ep, cause, c;
    cyc_t        idle;
    idle = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
    ir = st[0] && !st[1] && ((hw & st[15:10]) != 6'd0);
    exp_q.delete();
    if (ev || ir) begin
      ep    = bd ? pc - 32'd4 : pc;
      c     = ev ? {27'd0, code} : 32'd0;
      cause = ({31'd0, bd} << 31) | ({26'd0, hw} << 10) | (c << 2);
      exp_q.push_back('{1'b1, 5'd14, ep, 1'b1, 1'b0, 1'b0, 32'd0});
      exp_q.push_back('{1'b1, 5'd13, cause, 1'b1, 1'b0, 1'b0, 32'd0});
      exp_q.push_back('{1'b1, 5'd12, st | 32'h2, 1'b1, 1'b0, 1'b0, 32'd0});
      exp_q.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h180});
    end else if (er) begin
      exp_q.push_back('{1'b1, 5'd12, st & ~32'h2, 1'b1, 1'b0, 1'b0, 32'd0});
      exp_q.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, epc});
    end
    exp_q.push_back(idle);
  endfunction

  task automatic quiet();
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; eret = 0; hw_int = 0;
  endtask

  task automatic noise();
    exc_valid = 1'($urandom); eret = 1'($urandom); hw_int = 6'($urandom);
    exc_pc = $urandom; exc_code = 5'($urandom); exc_bd = 1'($urandom);
  endtask

  task automatic clear_timer();
`ifdef EXC_CTRL_TIMER_EN
    mtc0_valid = 1; mtc0_addr = 5'd11; mtc0_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mtc0_valid = 0;
`endif
  endtask

  // Present one request in IDLE and compare every following cycle to the model.
  task automatic run_txn(input logic ev, input logic [4:0] code, input logic [31:0] pc,
                         input logic bd, input logic er, input logic [5:0] hw,
                         input logic [31:0] st, input logic [31:0] epc, input bit noisy);
    cyc_t e;
    model(ev, code, pc, bd, er, hw, st, epc);
    obs_din.delete(); obs_addr.delete(); obs_rpc = 'x;
    exc_valid = ev; exc_code = code; exc_pc = pc; exc_bd = bd; eret = er; hw_int = hw;
    cp0_status = st; cp0_epc = epc;
    @(posedge clk); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      if (noisy) noise(); else quiet();
      checks++;
      if (cp0_write !== e.wr || stall !== e.stall || flush !== e.flush ||
          redirect_valid !== e.rv) begin
        errors++;
        $display("FAIL ctrl[%0d]: got wr=%b st=%b fl=%b rv=%b want wr=%b st=%b fl=%b rv=%b",
                 k, cp0_write, stall, flush, redirect_valid, e.wr, e.stall, e.flush, e.rv);
      end
      checks++;
      if (cp0_selW !== 6'd0) begin
        errors++; $display("FAIL selW: got %h want 0", cp0_selW);
      end
      if (e.wr) begin
        obs_din.push_back(cp0_din); obs_addr.push_back(cp0_addrW);
        checks++;
        if (cp0_addrW !== e.addr || cp0_din !== e.din) begin
          errors++;
          $display("FAIL write[%0d]: got addr=%0d din=%h want addr=%0d din=%h",
                   k, cp0_addrW, cp0_din, e.addr, e.din);
        end
      end
      if (e.rv) begin
        obs_rpc = redirect_pc;
        checks++;
        if (redirect_pc !== e.rpc) begin
          errors++; $display("FAIL redirect_pc: got %h want %h", redirect_pc, e.rpc);
        end
      end
      if (k < exp_q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    quiet();
  endtask

  task automatic test_reset();
    rst = 1; quiet(); cp0_status = 0; cp0_epc = 0;
    mtc0_valid = 0; mtc0_addr = 0; mtc0_data = 0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({cp0_write, stall, flush, redirect_valid} !== 4'b0 || cp0_addrW !== 5'd0 ||
        cp0_din !== 32'd0 || redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset: got wr=%b st=%b fl=%b rv=%b addr=%0d din=%h rpc=%h want all 0",
               cp0_write, stall, flush, redirect_valid, cp0_addrW, cp0_din, redirect_pc);
    end
    rst = 0;
    clear_timer();
  endtask

  task automatic test_exception();
    run_txn(1, 5'd12, 32'h0040_0010, 0, 0, 6'd0, 32'h0, 32'h0, 0);
    checks++;
    if (obs_din.size() != 3 || obs_din[0] !== 32'h0040_0010 || obs_din[1] !== 32'h0000_0030 ||
        obs_rpc !== 32'h180) begin
      errors++; $display("FAIL exc_basic: got epc=%h cause=%h rpc=%h want 00400010 00000030 180",
                         obs_din[0], obs_din[1], obs_rpc);
    end
  endtask

  task automatic test_delay_slot();
    run_txn(1, 5'd12, 32'h0040_0010, 1, 0, 6'd0, 32'h0, 32'h0, 0);
    checks++;
    if (obs_din[0] !== 32'h0040_000C || obs_din[1][31] !== 1'b1) begin
      errors++; $display("FAIL exc_bd: got epc=%h cause=%h want 0040000C bd=1",
                         obs_din[0], obs_din[1]);
    end
    run_txn(1, 5'd4, 32'h0, 1, 0, 6'd0, 32'h0, 32'h0, 0);
    checks++;
    if (obs_din[0] !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL epc_wrap: got %h want FFFFFFFC", obs_din[0]);
    end
  endtask

  task automatic test_interrupt();
    run_txn(0, 5'd0, 32'h0040_0100, 0, 0, 6'b000001, 32'h0000_0401, 32'h0, 0);
    checks++;
    if (obs_din.size() != 3 || obs_din[1][10] !== 1'b1 || obs_din[1][6:2] !== 5'd0 ||
        obs_din[0] !== 32'h0040_0100) begin
      errors++; $display("FAIL int_taken: got %0d writes cause=%h want cause[10]=1 code 0",
                         obs_din.size(), obs_din[1]);
    end
    run_txn(0, 5'd0, 32'h0040_0100, 0, 0, 6'b000001, 32'h0000_0403, 32'h0, 0);
    checks++;
    if (obs_din.size() != 0) begin
      errors++; $display("FAIL int_exl_masked: got %0d writes want 0", obs_din.size());
    end
  endtask

  task automatic test_eret();
    run_txn(0, 5'd0, 32'h0, 0, 1, 6'd0, 32'h3, 32'h0040_0020, 0);
    checks++;
    if (obs_din.size() != 1 || obs_din[0] !== 32'h1 || obs_rpc !== 32'h0040_0020) begin
      errors++; $display("FAIL eret: got status=%h rpc=%h want 00000001 00400020",
                         obs_din[0], obs_rpc);
    end
    run_txn(1, 5'd8, 32'h0040_0040, 0, 1, 6'd0, 32'h3, 32'h0040_0020, 0);
    checks++;
    if (obs_din.size() != 3 || obs_addr[0] !== 5'd14 || obs_rpc !== 32'h180) begin
      errors++; $display("FAIL exc_over_eret: got %0d writes rpc=%h want 3 writes rpc 180",
                         obs_din.size(), obs_rpc);
    end
  endtask

  task automatic test_rst_mid();
    exc_valid = 1; exc_code = 5'd10; exc_pc = 32'h0040_0080; exc_bd = 0;
    cp0_status = 0;
    @(posedge clk); #1;
    quiet();
    @(posedge clk); #1;
    checks++;
    if (cp0_addrW !== 5'd13 || cp0_write !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: got addr=%0d wr=%b want 13 1", cp0_addrW, cp0_write);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (cp0_write !== 1'b0 || stall !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got wr=%b st=%b rv=%b fl=%b want 0 0 0 0",
                         cp0_write, stall, redirect_valid, flush);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cp0_write !== 1'b0 || redirect_valid !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("FAIL rst_mid_after[%0d]: got wr=%b rv=%b st=%b want 0 0 0",
                           i, cp0_write, redirect_valid, stall);
      end
    end
    clear_timer();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] st;
      st = ($urandom & 32'h0000_FC03) | ($urandom & 32'hFFFF_0000);
      run_txn(($urandom_range(0, 2) == 0), 5'($urandom), $urandom, 1'($urandom),
              1'($urandom), 6'($urandom), st, $urandom, 1);
    end
  endtask

  task automatic test_timer();
`ifdef EXC_CTRL_TIMER_EN
    int n;
    quiet(); cp0_status = 0;
    mtc0_valid = 1; mtc0_addr = 5'd11; mtc0_data = 32'd5;
    @(posedge clk); #1;
    mtc0_addr = 5'd9; mtc0_data = 32'd0;
    @(posedge clk); #1;
    mtc0_valid = 0; cp0_status = 32'h0000_8001;
    n = 0;
    while (stall !== 1'b1 && n < 12) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n < 6 || n > 8) begin
      errors++; $display("FAIL timer_latency: got %0d cycles want 6..8", n);
    end
    @(posedge clk); #1;
    checks++;
    if (cp0_addrW !== 5'd13 || cp0_din[15] !== 1'b1) begin
      errors++; $display("FAIL timer_cause: got addr=%0d din=%h want 13 bit15", cp0_addrW, cp0_din);
    end
    cp0_status = 0;
    repeat (3) @(posedge clk); #1;
    clear_timer();
`endif
  endtask

  initial begin
    test_reset();
    test_exception();
    test_delay_slot();
    test_interrupt();
    test_eret();
    test_rst_mid();
    test_timer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
